// File: rtl/ads8689_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters of an ADS8689 ADC.
// Optional WAIT-state timeout abort is compiled in with ADS8689_SPI_ARB_TIMEOUT_EN.
module ads8689_spi_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_mosi_data,
  output logic [N_REQ-1:0]            o_ack,
  output logic                        o_err,
  output logic [DATA_WIDTH-1:0]       o_rdata,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_spi_start,
  output logic [DATA_WIDTH-1:0]       o_spi_mosi_data,
  input  logic                        i_spi_data_valid,
  input  logic [DATA_WIDTH-1:0]       i_spi_miso_data,
  output logic                        o_busy,
  output logic [2:0]                  o_debug_state
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0]   N_REQ_W   = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ-1);
  localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      last_winner;
  logic [IDX_W-1:0]      winner;
  logic [7:0]            gap_cnt;

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W:0]        cand;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef ADS8689_SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_busy        = (state != S_IDLE);
  assign o_debug_state = state;

  // Search starts one past the last winner; cand stays below 2*N_REQ so one wrap suffices.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_winner} + (IDX_W+1)'(i);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!sel_found && i_req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign sel_data = i_req_mosi_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      last_winner     <= LAST_INIT;
      winner          <= '0;
      gap_cnt         <= '0;
      o_ack           <= '0;
      o_grant         <= '0;
      o_spi_start     <= 1'b0;
      o_rdata         <= '0;
      o_spi_mosi_data <= '0;
`ifdef ADS8689_SPI_ARB_TIMEOUT_EN
      wait_cnt        <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      o_ack       <= '0;
      o_spi_start <= 1'b0;
`ifdef ADS8689_SPI_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            winner          <= sel_idx;
            o_spi_mosi_data <= sel_data;
            o_grant         <= N_REQ'(1) << sel_idx;
            state           <= S_START;
          end
        end
        S_START: begin
          o_spi_start <= 1'b1;
`ifdef ADS8689_SPI_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // A frame arriving on the timeout cycle still wins: no error is flagged.
          if (i_spi_data_valid) begin
            o_rdata <= i_spi_miso_data;
            o_ack   <= o_grant;
            state   <= S_DONE;
          end
`ifdef ADS8689_SPI_ARB_TIMEOUT_EN
          else if (wait_cnt == TO_MAX) begin
            o_rdata <= '0;
            o_ack   <= o_grant;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          last_winner <= winner;
          o_grant     <= '0;
          gap_cnt     <= '0;
          state       <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: begin
          o_grant <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads8689_spi_arbiter.sv
// Directed bench for ads8689_spi_arbiter: vector table of single transactions plus
// hand sequences for fairness, reset abort, stray valid and WAIT timeout.
module tb_ads8689_spi_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] mosi_in;
  logic [N-1:0]  ack;
  logic          err;
  logic [DW-1:0] rdata;
  logic [N-1:0]  grant;
  logic          start;
  logic [DW-1:0] spi_mosi;
  logic          valid;
  logic [DW-1:0] miso;
  logic          busy;
  logic [2:0]    dstate;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ads8689_spi_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_mosi_data(mosi_in),
    .o_ack(ack), .o_err(err), .o_rdata(rdata), .o_grant(grant),
    .o_spi_start(start), .o_spi_mosi_data(spi_mosi),
    .i_spi_data_valid(valid), .i_spi_miso_data(miso),
    .o_busy(busy), .o_debug_state(dstate)
  );

  typedef struct {
    logic [3:0]  req;
    bit          hold;
    int          lat;
    logic [31:0] miso;
    logic [3:0]  exp_ack;
    logic [31:0] exp_mosi;
    bit          stray;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " return to idle"}, busy, 1'b0);
  endtask

  // Starts at a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input string name);
    req = v.req;
    @(negedge clk);
    if (!v.hold) req = '0;
    chk({name, " grant"}, grant, v.exp_ack);
    chk({name, " start early"}, start, 1'b0);
    chk({name, " state start"}, dstate, 3'd1);
    @(negedge clk);
    chk({name, " start pulse"}, start, 1'b1);
    chk({name, " mosi"}, spi_mosi, v.exp_mosi);
    chk({name, " state wait"}, dstate, 3'd2);
    for (int i = 0; i < v.lat; i++) begin
      @(negedge clk);
      if (i == 0) chk({name, " start width"}, start, 1'b0);
    end
    valid = 1'b1;
    miso  = v.miso;
    @(negedge clk);
    valid = 1'b0;
    miso  = 32'h5555AAAA;
    req   = '0;
    chk({name, " ack"}, ack, v.exp_ack);
    chk({name, " rdata"}, rdata, v.miso);
    chk({name, " err"}, err, 1'b0);
    chk({name, " grant done"}, grant, v.exp_ack);
    @(negedge clk);
    chk({name, " ack width"}, ack, 4'b0);
    chk({name, " grant clear"}, grant, 4'b0);
    if (v.stray) begin
      valid = 1'b1;
      miso  = ~v.miso;
      @(negedge clk);
      valid = 1'b0;
      chk({name, " stray gap state"}, dstate, 3'd4);
      chk({name, " stray gap rdata"}, rdata, v.miso);
      chk({name, " stray gap ack"}, ack, 4'b0);
    end
    wait_idle(name);
  endtask

  initial begin
    logic [3:0] fair_exp [5];
    int pend, nack, gaps;

    //           req      hold lat miso          ack      mosi          stray
    tbl[0] = '{4'b0001, 1'b1, 16, 32'h00001234, 4'b0001, 32'hD0140001, 1'b0};
    tbl[1] = '{4'b0110, 1'b1,  3, 32'hCAFEBABE, 4'b0010, 32'hA5A50002, 1'b0};
    tbl[2] = '{4'b0110, 1'b1,  1, 32'h0BADF00D, 4'b0100, 32'h3C3C0003, 1'b0};
    tbl[3] = '{4'b0011, 1'b1,  5, 32'h13579BDF, 4'b0001, 32'hD0140001, 1'b1};
    tbl[4] = '{4'b0100, 1'b0,  4, 32'h2468ACE0, 4'b0100, 32'h3C3C0003, 1'b0};
    tbl[5] = '{4'b1001, 1'b1,  0, 32'hFFFFFFFF, 4'b1000, 32'hFFFF0004, 1'b0};
    tbl[6] = '{4'b1111, 1'b1,  2, 32'h80000001, 4'b0001, 32'hD0140001, 1'b0};
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst     = 1'b1;
    req     = '0;
    valid   = 1'b0;
    miso    = '0;
    mosi_in = {32'hFFFF0004, 32'h3C3C0003, 32'hA5A50002, 32'hD0140001};
    repeat (3) @(negedge clk);
    chk("reset state", dstate, 3'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset grant", grant, 4'b0);
    chk("reset ack", ack, 4'b0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mosi", spi_mosi, 32'h0);
    chk("reset start", start, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) run_txn(tbl[t], $sformatf("vec%0d", t));

    // Stray valid in IDLE
    valid = 1'b1;
    miso  = 32'hDEADBEEF;
    @(negedge clk);
    valid = 1'b0;
    chk("stray idle state", dstate, 3'd0);
    chk("stray idle rdata", rdata, 32'h80000001);
    chk("stray idle ack", ack, 4'b0);

    // Reset during WAIT: requester 2 wins, then is aborted
    req = 4'b0100;
    repeat (3) @(negedge clk);
    chk("abort pre state", dstate, 3'd2);
    rst   = 1'b1;
    valid = 1'b1;
    miso  = 32'h77777777;
    @(negedge clk);
    chk("abort state", dstate, 3'd0);
    chk("abort grant", grant, 4'b0);
    chk("abort ack", ack, 4'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort rdata", rdata, 32'h0);
    chk("abort mosi", spi_mosi, 32'h0);
    chk("abort start", start, 1'b0);
    chk("abort err", err, 1'b0);
    rst   = 1'b0;
    valid = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("abort no late ack", ack, 4'b0);

    // Fairness with all requests held
    req  = 4'b1111;
    pend = 0;
    nack = 0;
    gaps = 0;
    for (int c = 0; c < 300 && nack < 5; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (|ack) begin
        if (nack > 0) chk($sformatf("fair gap %0d", nack), gaps, GAP);
        chk($sformatf("fair order %0d", nack), ack, fair_exp[nack]);
        nack++;
        gaps = 0;
      end
      if (dstate == 3'd4) gaps++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          valid = 1'b1;
          miso  = 32'h100 + c;
        end
      end
      if (start) pend = 3;
    end
    chk("fair ack count", nack, 5);
    req   = '0;
    valid = 1'b0;
    wait_idle("fair");

    // WAIT timeout
    req = 4'b0001;
    repeat (2) @(negedge clk);
    chk("to start", start, 1'b1);
`ifdef ADS8689_SPI_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) @(negedge clk);
    chk("to early ack", ack, 4'b0);
    @(negedge clk);
    chk("to ack", ack, 4'b0001);
    chk("to err", err, 1'b1);
    chk("to rdata", rdata, 32'h0);
    req = '0;
    @(negedge clk);
    chk("to err width", err, 1'b0);
    wait_idle("to");
    // Valid on the timeout cycle takes priority
    req = 4'b0001;
    repeat (2) @(negedge clk);
    for (int k = 1; k <= 16; k++) @(negedge clk);
    valid = 1'b1;
    miso  = 32'h0000ABCD;
    @(negedge clk);
    valid = 1'b0;
    req   = '0;
    chk("to prio ack", ack, 4'b0001);
    chk("to prio err", err, 1'b0);
    chk("to prio rdata", rdata, 32'h0000ABCD);
    wait_idle("to prio");
`else
    repeat (40) @(negedge clk);
    chk("no-to busy", busy, 1'b1);
    chk("no-to state", dstate, 3'd2);
    chk("no-to err", err, 1'b0);
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("no-to recover", dstate, 3'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
